// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM state encoding and request classification for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_WR0,
        S_WR1,
        S_RESP
    } state_t;

    typedef struct packed {
        logic legal;
        logic misal;
    } req_class_t;

    function automatic req_class_t classify(input logic we, input logic [2:0] f3, input logic [1:0] off);
        req_class_t c;
        if (we)
            c.legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            c.legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
        c.misal = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        return c;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: extracts/extends load data from a {hi,lo} word pair and
// merges store data into the old words (read-modify-write), for any byte offset.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic        sel_hi,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [4:0]  sh;
    logic [63:0] pair;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [63:0] mask64;
    logic [63:0] data64;
    logic [63:0] merged;

    assign sh      = {off, 3'b000};
    assign pair    = {hi, lo};
    assign shifted = 32'(pair >> sh);

    always_comb begin
        ld_data = shifted;
        case (funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data = {24'b0, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data = {16'b0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_comb begin
        mask = 32'hFFFF_FFFF;
        case (funct3[1:0])
            2'b00:   mask = 32'h0000_00FF;
            2'b01:   mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
    end

    // Lanes outside the access keep the previously read bytes.
    assign mask64  = {32'b0, mask} << sh;
    assign data64  = {32'b0, wdata} << sh;
    assign merged  = (pair & ~mask64) | (data64 & mask64);
    assign st_word = sel_hi ? merged[63:32] : merged[31:0];

endmodule

// File: rtl/load_store_unit.sv
// Load/store stage: one request per IDLE handshake, aligned word accesses, single-cycle response.
// Misaligned accesses split across two words when LSU_MISALIGN_SPLIT_EN is defined, else fault.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [31:0]       MemWriteData,
    output logic              MemW,
    output logic [2:0]        MemFunct3,
    input  logic [31:0]       MemReadData
);

    localparam logic [1:0] CNT_INIT = 2'(MEM_RD_LAT - 1);

    state_t            state;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;
    logic [31:0]       hi_q;
    logic              fault_q;

    req_class_t        cls;
    logic              req_fault;
    logic [ADDR_W-1:0] req_word;
    logic [ADDR_W-1:0] word0;
    logic [31:0]       lo_in;
    logic [31:0]       hi_in;
    logic [31:0]       ld_data;
    logic [31:0]       st_word;

    assign MemFunct3 = F3_W;
    assign cls       = classify(req_we, req_funct3, req_addr[1:0]);
    assign req_word  = {req_addr[ADDR_W-1:2], 2'b00};
    assign word0     = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
    logic              split_q;
    logic [ADDR_W-1:0] word1;
    assign word1     = word0 + ADDR_W'(4);
    assign req_fault = !cls.legal;
`else
    assign req_fault = !cls.legal || cls.misal;
`endif

    // The merge sees the word being captured this cycle so the write can issue on the next edge.
    assign lo_in = (state == S_RD0) ? MemReadData : lo_q;
    assign hi_in = (state == S_RD1) ? MemReadData : hi_q;

    lsu_lane_align u_align (
        .lo      (lo_in),
        .hi      (hi_in),
        .off     (addr_q[1:0]),
        .funct3  (f3_q),
        .wdata   (wdata_q),
        .sel_hi  (state == S_WR0),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= S_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            fault_q      <= 1'b0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_fault   <= 1'b0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            MemW         <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q      <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    addr_q    <= req_addr;
                    we_q      <= req_we;
                    f3_q      <= req_funct3;
                    wdata_q   <= req_wdata;
                    fault_q   <= req_fault;
`ifdef LSU_MISALIGN_SPLIT_EN
                    split_q   <= cls.misal;
`endif
                    if (req_fault) begin
                        state <= S_RESP;
                    end else if (req_we && req_funct3 == F3_W && !cls.misal) begin
                        state        <= S_WR0;
                        MemW         <= 1'b1;
                        MemAddress   <= req_word;
                        MemWriteData <= req_wdata;
                    end else begin
                        state      <= S_RD0;
                        MemAddress <= req_word;
                        cnt        <= CNT_INIT;
                    end
                end
                S_RD0: if (cnt != 2'd0) begin
                    cnt <= cnt - 2'd1;
                end else begin
                    lo_q <= MemReadData;
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (split_q) begin
                        state      <= S_RD1;
                        MemAddress <= word1;
                        cnt        <= CNT_INIT;
                    end else
`endif
                    if (we_q) begin
                        state        <= S_WR0;
                        MemW         <= 1'b1;
                        MemWriteData <= st_word;
                    end else begin
                        state <= S_RESP;
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                S_RD1: if (cnt != 2'd0) begin
                    cnt <= cnt - 2'd1;
                end else begin
                    hi_q <= MemReadData;
                    if (we_q) begin
                        state        <= S_WR0;
                        MemW         <= 1'b1;
                        MemAddress   <= word0;
                        MemWriteData <= st_word;
                    end else begin
                        state <= S_RESP;
                    end
                end
                S_WR0: if (split_q) begin
                    state        <= S_WR1;
                    MemAddress   <= word1;
                    MemWriteData <= st_word;
                end else begin
                    state <= S_RESP;
                    MemW  <= 1'b0;
                end
                S_WR1: begin
                    state <= S_RESP;
                    MemW  <= 1'b0;
                end
`else
                S_WR0: begin
                    state <= S_RESP;
                    MemW  <= 1'b0;
                end
`endif
                S_RESP: begin
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b1;
                    resp_fault <= fault_q;
                    resp_rdata <= (fault_q || we_q) ? 32'd0 : ld_data;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    MemW      <= 1'b0;
                end
            endcase
        end
    end

endmodule
